micro_sequencer: RTL
====================

// Module: micro_sequencer
// PURPOSE
// Microprogrammed control unit directly upstream of the ALU/shifter/register-file datapath.
// Holds a writable control store. On start, steps through microinstructions and drives the datapath's
// alu_opcode, shifter_opcode, c_select and b_select each cycle. Branches on the datapath's n/z flags.
// Runs until a HALT microinstruction is reached or a step watchdog expires.
// PARAMETERS
// ADDR_W     8    control-store address width; DEPTH = 2**ADDR_W words
// MAX_STEPS  1024 executed microinstructions before forced abort (watchdog)
// Word format (32b), MSB first:
//   [31:26] alu_opcode, [25:24] shifter_opcode, [23:15] c_select, [14:11] b_select,
//   [10:8] cond, [7:0] next_addr
// PORTS
// clock           in   1       single clock, all state updates on posedge
// reset           in   1       synchronous, active-high
// start           in   1       begin execution at start_addr (honoured only in IDLE)
// start_addr      in   ADDR_W  entry point of microprogram
// load_en         in   1       write load_data to control store (honoured only in IDLE)
// load_addr       in   ADDR_W  control-store write address
// load_data       in   32      microinstruction word
// n               in   1       datapath negative flag for the current microinstruction
// z               in   1       datapath zero flag for the current microinstruction
// alu_opcode      out  6       MIR[31:26]
// shifter_opcode  out  2       MIR[25:24]
// c_select        out  9       MIR[23:15]; 0 = no register written
// b_select        out  4       MIR[14:11]
// mpc_out         out  ADDR_W  address of the microinstruction currently in MIR
// busy            out  1       high in RUN
// done            out  1       one-cycle pulse on normal HALT completion
// error           out  1       one-cycle pulse on watchdog abort
// BEHAVIOUR
// Reset: state=IDLE, MIR=0 (so all control outputs 0), mpc=0, step=0, busy/done/error=0.
//   The control store is not cleared.
// Store: synchronous write, asynchronous read. load_en in RUN/DONE is ignored.
//   If start and load_en are both high in IDLE, start wins and the write is dropped.
// Three-state FSM:
// IDLE: outputs come from MIR = 0. On start:
//   MIR<=store[start_addr], mpc<=start_addr, step<=1, next state RUN.
//   The first microinstruction is on the outputs the cycle after start is sampled.
// RUN: outputs = MIR fields, combinational from the MIR register. Each edge evaluates cond
//   against the n/z presented that cycle:
//   000 seq:   next=mpc+1
//   001 jmp:   next=next_addr
//   010 jn:    next = n ? next_addr : mpc+1
//   011 jz:    next = z ? next_addr : mpc+1
//   100 jnz:   next = !z ? next_addr : mpc+1
//   101 halt:  MIR<=0, go DONE, done=1 for the DONE cycle
//   11x: reserved, treated as seq
//   Otherwise: mpc<=next, MIR<=store[next], step<=step+1.
//   mpc+1 wraps mod DEPTH (255 -> 0).
// Watchdog: if step==MAX_STEPS and the current MI is not halt:
//   MIR<=0, go DONE with error=1 instead of done; halt on that same MI takes precedence.
// DONE: one cycle, outputs 0, then IDLE. start during RUN/DONE is ignored (not queued).
// Every executed microinstruction (including halt) is on the outputs for exactly one cycle.
// reset in any state returns to IDLE on that edge; an in-flight program is abandoned with no done/error.
// TESTING
// 1. Reset: assert reset 2 cycles -> all outputs 0, busy=0. Load store[0..2]; start_addr=0.
//    Expect alu_opcode sequence 6'b110001, 6'b111001, 6'b111001 on consecutive cycles.
//    Expect done one cycle after the halt word (store[2] cond=101). busy is high for 3 cycles.
// 2. Branch: store[5] cond=011, next_addr=8h20. z=1 -> mpc_out 8h20 next cycle.
//    Repeat with z=0 -> 8h06. Also check jn and jnz with both flag values.
// 3. Wrap: start_addr=8hFF with cond=000 -> next mpc_out=8h00. store[0] halt -> done pulse.
// 4. Watchdog: MAX_STEPS=16, store[3]: jmp to 3 -> error pulses after exactly 16 outputs cycles.
//    done stays 0 and outputs return to 0.
// 5. Ignored inputs: start and load_en pulsed while busy -> no restart, store unchanged.
//    start and load_en together in IDLE -> run starts, write dropped.
// 6. Mid-run reset: assert reset on 3rd microinstruction -> next cycle IDLE, outputs 0, no done/error.
//    A new start then runs normally.

Source files
------------

// File: rtl/micro_sequencer_if.sv
// Control-store load, start and flag inputs plus the datapath control outputs
// exchanged between the micro-sequencer and its environment.
interface micro_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              n;
    logic              z;
    logic [5:0]        alu_opcode;
    logic [1:0]        shifter_opcode;
    logic [8:0]        c_select;
    logic [3:0]        b_select;
    logic [ADDR_W-1:0] mpc_out;
    logic              busy;
    logic              done;
    logic              error;

    modport slave (
        input  start, start_addr, load_en, load_addr, load_data, n, z,
        output alu_opcode, shifter_opcode, c_select, b_select, mpc_out, busy, done, error
    );

    modport master (
        output start, start_addr, load_en, load_addr, load_data, n, z,
        input  alu_opcode, shifter_opcode, c_select, b_select, mpc_out, busy, done, error
    );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: writable control store, n/z branching,
// HALT completion and a step watchdog that aborts runaway microprograms.
module micro_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int MAX_STEPS = 1024
) (
    input logic               clock,
    input logic               reset,
    micro_sequencer_if.slave  bus
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] C_SEQ  = 3'b000;
    localparam logic [2:0] C_JMP  = 3'b001;
    localparam logic [2:0] C_JN   = 3'b010;
    localparam logic [2:0] C_JZ   = 3'b011;
    localparam logic [2:0] C_JNZ  = 3'b100;
    localparam logic [2:0] C_HALT = 3'b101;

    logic [31:0]       store_q [DEPTH];
    logic [1:0]        state_q, state_d;
    logic [31:0]       mir_q, mir_d;
    logic [ADDR_W-1:0] mpc_q, mpc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              store_we_s;
    logic [ADDR_W-1:0] next_addr_s;

    // Reserved conditions (11x) fall through to sequential like seq.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [2:0]        cond,
        input logic              flag_n,
        input logic              flag_z,
        input logic [ADDR_W-1:0] mpc,
        input logic [ADDR_W-1:0] target
    );
        logic [ADDR_W-1:0] inc;
        inc = mpc + ADDR_W'(1);
        case (cond)
            C_JMP:   return target;
            C_JN:    return flag_n ? target : inc;
            C_JZ:    return flag_z ? target : inc;
            C_JNZ:   return flag_z ? inc : target;
            default: return inc;
        endcase
    endfunction

    assign next_addr_s = branch_target(mir_q[10:8], bus.n, bus.z, mpc_q, mir_q[ADDR_W-1:0]);

    // Next-state, MIR and status computation for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d    = state_q;
        mir_d      = mir_q;
        mpc_d      = mpc_q;
        step_d     = step_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        store_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    mir_d   = store_q[bus.start_addr];
                    mpc_d   = bus.start_addr;
                    step_d  = STEP_W'(1);
                    busy_d  = 1'b1;
                end else begin
                    store_we_s = bus.load_en & ~reset;
                end
            end
            ST_RUN: begin
                if (mir_q[10:8] == C_HALT) begin
                    state_d = ST_DONE;
                    mir_d   = 32'd0;
                    done_d  = 1'b1;
                end else if (step_q == STEP_W'(MAX_STEPS)) begin
                    state_d = ST_DONE;
                    mir_d   = 32'd0;
                    error_d = 1'b1;
                end else begin
                    mpc_d  = next_addr_s;
                    mir_d  = store_q[next_addr_s];
                    step_d = step_q + STEP_W'(1);
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                mir_d   = 32'd0;
            end
            default: begin
                state_d = ST_IDLE;
                mir_d   = 32'd0;
            end
        endcase
    end

    // Controller state and registered status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mir_q   <= 32'd0;
            mpc_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mir_q   <= mir_d;
            mpc_q   <= mpc_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Control store write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (store_we_s) begin
            store_q[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.alu_opcode     = mir_q[31:26];
    assign bus.shifter_opcode = mir_q[25:24];
    assign bus.c_select       = mir_q[23:15];
    assign bus.b_select       = mir_q[14:11];
    assign bus.mpc_out        = mpc_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
endmodule
